// File: rtl/trace_pkg.sv
// Shared definitions for the retire trace path: entry field layout and
// serializer state encoding.
package trace_pkg;

  localparam int ENTRY_W  = 70;
  localparam int PC_MSB   = 69;
  localparam int PC_LSB   = 38;
  localparam int WEN_BIT  = 37;
  localparam int DEST_MSB = 36;
  localparam int DEST_LSB = 32;
  localparam int RES_MSB  = 31;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_PC  = 2'd1,
    SEND_TAG = 2'd2,
    SEND_RES = 2'd3
  } trace_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with registered occupancy count.
// Full and empty are decoded from the count, so they reflect the pre-edge value.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 70
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             doPush;
  logic             doPop;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign rdata  = mem_q[rdPtr_q];
  assign count  = count_q;

  // Storage is deliberately left unreset; only pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/retire_trace_ctrl.sv
// Buffers retired-instruction trace entries from WB and serializes each one
// as three 32-bit words (pc, {wen,dest}, result) onto a valid/ready port.
module retire_trace_ctrl #(
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = trace_pkg::ENTRY_W,
  parameter int OCC_W   = $clog2(DEPTH+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               retired,
  input  logic [ENTRY_W-1:0] fifo_data,
  output logic               fifo_full,
  output logic               trace_valid,
  input  logic               trace_ready,
  output logic [31:0]        trace_data,
  output logic               trace_last,
  output logic [31:0]        retire_cnt,
  output logic [OCC_W-1:0]   occupancy
);

  import trace_pkg::*;

  trace_state_e       state_q, state_d;
  logic [ENTRY_W-1:0] hold_q, hold_d;
  logic [31:0]        retireCnt_q;
  logic [ENTRY_W-1:0] headData;
  logic [OCC_W-1:0]   occCount;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;

  assign push       = retired & ~full;
  assign fifo_full  = full;
  assign occupancy  = occCount;
  assign retire_cnt = retireCnt_q;

  sync_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata(fifo_data),
    .pop  (pop),
    .rdata(headData),
    .count(occCount),
    .full (full),
    .empty(empty)
  );

  // SEND_RES chains straight into the next entry's SEND_PC when storage is
  // non-empty, giving one entry per three cycles with no idle bubble.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    pop         = 1'b0;
    trace_valid = 1'b0;
    trace_last  = 1'b0;
    trace_data  = '0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          hold_d  = headData;
          state_d = SEND_PC;
        end
      end
      SEND_PC: begin
        trace_valid = 1'b1;
        trace_data  = hold_q[PC_MSB:PC_LSB];
        if (trace_ready) state_d = SEND_TAG;
      end
      SEND_TAG: begin
        trace_valid = 1'b1;
        trace_data  = {26'b0, hold_q[WEN_BIT], hold_q[DEST_MSB:DEST_LSB]};
        if (trace_ready) state_d = SEND_RES;
      end
      SEND_RES: begin
        trace_valid = 1'b1;
        trace_last  = 1'b1;
        trace_data  = hold_q[RES_MSB:0];
        if (trace_ready) begin
          if (!empty) begin
            pop     = 1'b1;
            hold_d  = headData;
            state_d = SEND_PC;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      retireCnt_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      if (push) retireCnt_q <= retireCnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_retire_trace_ctrl.sv
// Self-checking bench for retire_trace_ctrl: a cycle model tracks occupancy,
// serializer position and retire count; expected words queue on acceptance.
module tb_retire_trace_ctrl;

  localparam int DEPTH   = 8;
  localparam int ENTRY_W = 70;
  localparam int OCC_W   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               retired;
  logic [ENTRY_W-1:0] fifoData;
  logic               fifoFull;
  logic               traceValid;
  logic               traceReady;
  logic [31:0]        traceData;
  logic               traceLast;
  logic [31:0]        retireCnt;
  logic [OCC_W-1:0]   occupancy;

  int          assertCount = 0;
  int          failCount   = 0;
  int          mOcc;
  int          mWidx;
  logic [31:0] mCnt;
  int          peakOcc;
  logic [32:0] expQ[$];
  logic [32:0] obsQ[$];

  always #5 clk = ~clk;

  retire_trace_ctrl #(
    .DEPTH(DEPTH),
    .ENTRY_W(ENTRY_W),
    .OCC_W(OCC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .retired    (retired),
    .fifo_data  (fifoData),
    .fifo_full  (fifoFull),
    .trace_valid(traceValid),
    .trace_ready(traceReady),
    .trace_data (traceData),
    .trace_last (traceLast),
    .retire_cnt (retireCnt),
    .occupancy  (occupancy)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [69:0] makeEntry(input logic [31:0] pc, input logic wen,
                                            input logic [4:0] dest, input logic [31:0] res);
    return {pc, wen, dest, res};
  endfunction

  // One clock: compare outputs with the model, advance the model, then the DUT.
  task automatic applyStimulus();
    logic        doPush;
    logic        doPop;
    logic [32:0] w;
    checkOutput("valid", traceValid, mWidx != 0);
    checkOutput("occupancy", occupancy, mOcc);
    checkOutput("fifo_full", fifoFull, mOcc == DEPTH);
    checkOutput("retire_cnt", retireCnt, mCnt);
    if (int'(occupancy) > peakOcc) peakOcc = int'(occupancy);
    if (mWidx != 0 && traceReady && !rst) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_word", 1, 0);
      end else begin
        w = expQ.pop_front();
        checkOutput("data", traceData, w[31:0]);
        checkOutput("last", traceLast, w[32]);
      end
      obsQ.push_back({traceLast, traceData});
    end
    if (rst) begin
      mOcc  = 0;
      mWidx = 0;
      mCnt  = '0;
      expQ.delete();
    end else begin
      doPush = retired && (mOcc != DEPTH);
      doPop  = (mOcc != 0) && (mWidx == 0 || (mWidx == 3 && traceReady));
      if (mWidx == 0)       mWidx = doPop ? 1 : 0;
      else if (traceReady)  mWidx = (mWidx == 3) ? (doPop ? 1 : 0) : mWidx + 1;
      if (doPush) begin
        mCnt = mCnt + 32'd1;
        expQ.push_back({1'b0, fifoData[69:38]});
        expQ.push_back({1'b0, 26'b0, fifoData[37:32]});
        expQ.push_back({1'b1, fifoData[31:0]});
      end
      mOcc = mOcc + int'(doPush) - int'(doPop);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    rst        = 1'b1;
    retired    = 1'b0;
    traceReady = 1'b0;
    applyStimulus();
    rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    traceReady = 1'b1;
    retired    = 1'b0;
    while ((mWidx != 0 || mOcc != 0) && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("drain_done", n < budget, 1);
    applyStimulus();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          k;
    logic        acc;
    logic [31:0] pcVal;

    rst        = 1'b1;
    retired    = 1'b0;
    traceReady = 1'b0;
    fifoData   = '0;
    mOcc       = 0;
    mWidx      = 0;
    mCnt       = '0;
    peakOcc    = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    checkOutput("rst_valid", traceValid, 0);
    checkOutput("rst_last", traceLast, 0);
    checkOutput("rst_data", traceData, 0);
    checkOutput("rst_cnt", retireCnt, 0);
    checkOutput("rst_occ", occupancy, 0);
    checkOutput("rst_full", fifoFull, 0);

    // Single entry with exact word values and two-cycle latency.
    $display("[TB] single entry");
    obsQ.delete();
    traceReady = 1'b1;
    fifoData   = makeEntry(32'h8000_0010, 1'b1, 5'd3, 32'hDEAD_BEEF);
    retired    = 1'b1;
    applyStimulus();
    retired = 1'b0;
    applyStimulus();
    checkOutput("latency_valid", traceValid, 1);
    checkOutput("single_cnt", retireCnt, 1);
    drain(20);
    checkOutput("single_words", obsQ.size(), 3);
    checkOutput("single_w0", obsQ[0], {1'b0, 32'h8000_0010});
    checkOutput("single_w1", obsQ[1], {1'b0, 32'h0000_0023});
    checkOutput("single_w2", obsQ[2], {1'b1, 32'hDEAD_BEEF});

    // Back-to-back retires drain with no bubble.
    $display("[TB] back-to-back");
    obsQ.delete();
    peakOcc    = 0;
    traceReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pcVal    = 32'h100 + 32'(4 * i);
      fifoData = makeEntry(pcVal, 1'(i), 5'(i + 1), 32'hA000 + 32'(i));
      retired  = 1'b1;
      applyStimulus();
    end
    drain(40);
    checkOutput("b2b_peak", peakOcc, 3);
    checkOutput("b2b_words", obsQ.size(), 12);
    for (int i = 0; i < 4; i++) begin
      pcVal = 32'h100 + 32'(4 * i);
      checkOutput("b2b_pc", obsQ[3 * i], {1'b0, pcVal});
    end

    // Backpressure fill: storage plus hold reach nine entries.
    $display("[TB] backpressure fill");
    doReset();
    traceReady = 1'b0;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      fifoData = makeEntry(32'h4000 + 32'(4 * k), 1'b1, 5'(k), 32'h5000 + 32'(k));
      retired  = 1'b1;
      acc      = (mOcc != DEPTH);
      applyStimulus();
      if (acc) k++;
    end
    checkOutput("fill_full", fifoFull, 1);
    checkOutput("fill_occ", occupancy, 8);
    checkOutput("fill_cnt", retireCnt, 9);
    obsQ.delete();
    drain(100);
    checkOutput("fill_words", obsQ.size(), 27);

    // Stall in SEND_TAG keeps the word steady.
    $display("[TB] stall stability");
    traceReady = 1'b1;
    fifoData   = makeEntry(32'h7000_0000, 1'b0, 5'd17, 32'h1234_5678);
    retired    = 1'b1;
    applyStimulus();
    retired = 1'b0;
    applyStimulus();
    applyStimulus();
    traceReady = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checkOutput("stall_data", traceData, 32'h11);
      checkOutput("stall_last", traceLast, 0);
      applyStimulus();
    end
    traceReady = 1'b1;
    applyStimulus();
    checkOutput("stall_next", traceData, 32'h1234_5678);
    checkOutput("stall_next_last", traceLast, 1);
    drain(20);

    // Pointer wrap with random consumer readiness.
    $display("[TB] pointer wrap");
    obsQ.delete();
    k = 0;
    for (int c = 0; c < 400 && k < 20; c++) begin
      fifoData   = makeEntry(32'h2000 + 32'(4 * k), 1'(k), 5'(k), 32'hC000 + 32'(k));
      retired    = 1'b1;
      traceReady = 1'($urandom_range(0, 1));
      acc        = (mOcc != DEPTH);
      applyStimulus();
      if (acc) k++;
    end
    checkOutput("wrap_accepted", k, 20);
    drain(200);
    checkOutput("wrap_occ", occupancy, 0);
    checkOutput("wrap_words", obsQ.size(), 60);

    // Reset while SEND_RES is presenting and five entries are stored.
    $display("[TB] mid-operation reset");
    traceReady = 1'b0;
    k = 0;
    for (int c = 0; c < 20 && k < 6; c++) begin
      fifoData = makeEntry(32'h9000 + 32'(4 * k), 1'b1, 5'd9, 32'hE000 + 32'(k));
      retired  = 1'b1;
      acc      = (mOcc != DEPTH);
      applyStimulus();
      if (acc) k++;
    end
    retired    = 1'b0;
    traceReady = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("pre_rst_last", traceLast, 1);
    checkOutput("pre_rst_occ", occupancy, 5);
    doReset();
    checkOutput("post_rst_valid", traceValid, 0);
    checkOutput("post_rst_occ", occupancy, 0);
    checkOutput("post_rst_full", fifoFull, 0);
    checkOutput("post_rst_cnt", retireCnt, 0);
    obsQ.delete();
    traceReady = 1'b1;
    fifoData   = makeEntry(32'hB000_0000, 1'b0, 5'd1, 32'h0000_00FF);
    retired    = 1'b1;
    applyStimulus();
    drain(20);
    checkOutput("post_rst_words", obsQ.size(), 3);
    checkOutput("post_rst_pc", obsQ[0], {1'b0, 32'hB000_0000});
    checkOutput("sb_empty", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/retire_trace_ctrl.md
Name: retire_trace_ctrl

Overview:
- Buffers retired-instruction trace entries from the writeback stage and drives WB backpressure through `fifo_full`.
- Drains each entry to a 32-bit trace/debug port under a valid/ready handshake, as three words per entry.
- Sits between WB and the off-core trace checker.
- Is the sole scheduler of WB retirement: WB stalls whenever this block is full.

Parameters:
- DEPTH, 8, number of entry slots in the storage FIFO (power of 2, ≥2).
- ENTRY_W, 70, trace entry width: {pc[69:38], wen[37], dest[36:32], result[31:0]}.
- OCC_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- retired  in  1  WB has a valid instruction this cycle.
- fifo_data  in  ENTRY_W  trace entry from WB.
- fifo_full  out  1  storage full; WB must hold.
- trace_valid  out  1  trace_data holds a valid word.
- trace_ready  in  1  consumer accepts the word.
- trace_data  out  32  current trace word.
- trace_last  out  1  current word is the final word of its entry.
- retire_cnt  out  32  count of entries accepted from WB.
- occupancy  out  OCC_W  entries held in storage (excludes the entry being serialized).

Behaviour:
- Reset values: fifo_full=0, trace_valid=0, trace_last=0, trace_data=0, retire_cnt=0, occupancy=0, FSM=IDLE, read/write pointers=0. Storage RAM is not reset.
- fifo_full = (occupancy == DEPTH), derived combinationally from the registered count.
- Push: push = retired & ~fifo_full. On push, write fifo_data at wr_ptr, increment wr_ptr modulo DEPTH, and increment retire_cnt (wraps 0xFFFFFFFF→0).
- If retired arrives while full, nothing is written. The entry is not lost, because WB holds it (WB ready_go = ~fifo_full).
- Pop: the FSM pops the head into a 70-bit holding register `hold`. It increments rd_ptr modulo DEPTH.
- Occupancy: push only → +1; pop only → -1; simultaneous push and pop → unchanged. Pointer wrap is independent of occupancy.
- FSM states: IDLE, SEND_PC, SEND_TAG, SEND_RES.
  - IDLE: if occupancy != 0, pop into hold and go to SEND_PC; else stay.
  - SEND_PC: trace_data = hold[69:38]. On trace_valid & trace_ready, go to SEND_TAG.
  - SEND_TAG: trace_data = {26'b0, hold[37], hold[36:32]}. On handshake, go to SEND_RES.
  - SEND_RES: trace_data = hold[31:0], trace_last=1. On handshake, if occupancy != 0 (pre-update value), pop the next entry and go to SEND_PC with no bubble; else go to IDLE.
- trace_valid = 1 in every SEND_* state and 0 in IDLE. trace_data and trace_last are driven from registered state and hold, and are stable while valid & ~ready.
- Latency: an entry pushed at edge E0 is popped at E1 when the FSM is IDLE. Its first word is valid after E1, i.e. no combinational bypass from fifo_data to trace_data.
- Throughput: one entry per 3 cycles with trace_ready held high. WB sustains one retire per cycle until DEPTH plus the hold entry are occupied.
- Simultaneous push into an empty FIFO while IDLE: the push lands at E0, occupancy becomes 1, and the pop occurs at E1.
- Simultaneous push and pop at full: the push is still blocked that cycle, because fifo_full is computed from the pre-pop count. It is accepted the next cycle.
- Reset mid-operation: the entry in hold and all stored entries are discarded, trace_valid drops the cycle after the reset edge, and retire_cnt clears.
- trace_ready low indefinitely: the FSM holds its word. Storage fills, fifo_full asserts, and WB stalls. No entry is dropped or reordered.

Decomposition:
- Shared package `trace_pkg` holds:
  - ENTRY_W and the field offsets PC_MSB=69, PC_LSB=38, WEN_BIT=37, DEST_MSB=36, DEST_LSB=32, RES_MSB=31.
  - The FSM state encoding (2 bits: IDLE=0, SEND_PC=1, SEND_TAG=2, SEND_RES=3).
- One sub-module, `sync_fifo`: parameterised DEPTH×ENTRY_W storage with pointers, occupancy, full and empty.
- The serializer FSM and retire counter stay in the top level.

Test Plan:
- Single entry: after reset, retired=1 for one cycle with fifo_data={32'h8000_0010, 1'b1, 5'd3, 32'hDEAD_BEEF}, trace_ready=1. Required response:
  - Words 32'h8000_0010, 32'h0000_0023, 32'hDEAD_BEEF on three consecutive cycles.
  - trace_last only on the third word.
  - First word valid two cycles after the retire cycle; retire_cnt=1.
- Back-to-back drain: 4 consecutive retires with pc=0x100,0x104,0x108,0x10C, trace_ready=1. Required response: 12 consecutive valid words with no bubble, pcs in order, occupancy peaking at 3.
- Backpressure fill: trace_ready=0 and retired=1 continuously. Required response:
  - occupancy reaches 8 and fifo_full=1 after the 9th accepted entry (8 stored plus hold).
  - retire_cnt stops at 9 while retired stays high.
  - When ready is raised, all 9 entries drain in order and fifo_full deasserts on the first pop.
- Stall stability: hold trace_ready=0 for 5 cycles during SEND_TAG. Required response: trace_data and trace_last are unchanged for all 5 cycles, the state is unchanged, and exactly one SEND_TAG word completes when ready rises.
- Pointer wrap: push and drain 20 entries with random trace_ready. Required response: output order matches input order across two wraps, and occupancy returns to 0.
- Mid-operation reset: assert rst during SEND_RES with occupancy=5. Required response: the next cycle has trace_valid=0, occupancy=0, fifo_full=0, retire_cnt=0; a following single retire emits only that entry.
